// File: rtl/l2reqfifo.sv
// L2 request FIFO: round-robin merge of L1 instruction/data requests into one ordered queue for l2tag.
// Optional macro L2REQFIFO_BYPASS_EN enables a same-cycle empty-FIFO bypass onto req_*.
module l2reqfifo #(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ic_req_valid,
  input  logic [31:2]             ic_req_addr,
  output logic                    ic_req_ready,
  input  logic                    dc_req_valid,
  input  logic [31:2]             dc_req_addr,
  input  logic                    dc_req_wen,
  input  logic [3:0]              dc_req_wmask,
  input  logic [31:0]             dc_req_wdata,
  output logic                    dc_req_ready,
  output logic                    req_valid,
  output logic [31:2]             req_addr,
  output logic                    req_wen,
  output logic [3:0]              req_wmask,
  output logic [31:0]             req_wdata,
  output logic                    req_src,
  input  logic                    l2_req_ready,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + 30 + 1 + 4 + 32;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rr_q, rr_d;

  logic          full, empty, grant_ic, grant_dc, enq, wr_en, rd_en;
  logic [EW-1:0] in_ent, out_ent;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    grant_ic     = ic_req_valid & (~dc_req_valid | ~rr_q);
    grant_dc     = dc_req_valid & (~ic_req_valid | rr_q);
    // Readiness never looks at l2_req_ready, so a full queue refuses even while draining.
    ic_req_ready = ~rst & ~full & ic_req_valid & grant_ic;
    dc_req_ready = ~rst & ~full & dc_req_valid & grant_dc;
    enq          = ic_req_ready | dc_req_ready;
    in_ent       = dc_req_ready ? {1'b1, dc_req_addr, dc_req_wen, dc_req_wmask, dc_req_wdata}
                                : {1'b0, ic_req_addr, 1'b0, 4'b0000, 32'h0};
    out_ent      = mem_q[rptr_q];
    req_valid    = ~rst & ~empty;
    wr_en        = enq;
    rd_en        = ~rst & ~empty & l2_req_ready;
`ifdef L2REQFIFO_BYPASS_EN
    if (empty && enq) begin
      req_valid = 1'b1;
      out_ent   = in_ent;
      wr_en     = ~l2_req_ready;
    end
`endif
    {req_src, req_addr, req_wen, req_wmask, req_wdata} = out_ent;
    fifo_count = rst ? '0 : count_q;
  end

  always_comb begin
    wptr_d  = wr_en ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = rd_en ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // After a grant the other source gets priority: rr=1 prefers the data side.
    rr_d = enq ? ic_req_ready : rr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rr_q    <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= in_ent;
  end
endmodule

// File: tb/tb_l2reqfifo.sv
// Self-checking bench for l2reqfifo: directed scenarios plus randomized traffic against a queue model.
// Honours L2REQFIFO_BYPASS_EN when the build defines it.
module tb_l2reqfifo;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst, ic_req_valid, ic_req_ready, dc_req_valid, dc_req_wen, dc_req_ready;
  logic req_valid, req_wen, req_src, l2_req_ready;
  logic [31:2] ic_req_addr, dc_req_addr, req_addr;
  logic [3:0] dc_req_wmask, req_wmask;
  logic [31:0] dc_req_wdata, req_wdata;
  logic [CW-1:0] fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        src;
    logic [29:0] addr;
    logic        wen;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } ent_t;

  ent_t mq[$];
  bit pref_dc;
  bit e_icr, e_dcr, e_vld, e_byp;
  ent_t e_head, acc_ent, act_head;
  logic [CW-1:0] e_cnt;

  assign act_head = {req_src, req_addr, req_wen, req_wmask, req_wdata};

  l2reqfifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_wen(dc_req_wen),
    .dc_req_wmask(dc_req_wmask), .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
    .req_valid(req_valid), .req_addr(req_addr), .req_wen(req_wen), .req_wmask(req_wmask),
    .req_wdata(req_wdata), .req_src(req_src), .l2_req_ready(l2_req_ready),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // Reference: a queue of accepted entries plus which side is preferred next.
  task automatic predict();
    bit full, gi, gd;
    full = (mq.size() == DEPTH);
    gi = ic_req_valid && (!dc_req_valid || !pref_dc);
    gd = dc_req_valid && (!ic_req_valid || pref_dc);
    e_icr = gi && !full;
    e_dcr = gd && !full;
    acc_ent = e_dcr ? ent_t'({1'b1, dc_req_addr, dc_req_wen, dc_req_wmask, dc_req_wdata})
                    : ent_t'({1'b0, ic_req_addr, 1'b0, 4'h0, 32'h0});
    e_cnt = CW'(mq.size());
    e_byp = 1'b0;
    e_head = '0;
    e_vld = (mq.size() > 0);
    if (e_vld) e_head = mq[0];
`ifdef L2REQFIFO_BYPASS_EN
    if (!e_vld && (e_icr || e_dcr)) begin
      e_vld = 1'b1;
      e_head = acc_ent;
      e_byp = 1'b1;
    end
`endif
  endtask

  task automatic commit();
    bit deq;
    deq = e_vld && l2_req_ready;
    if (!(e_byp && deq)) begin
      if (deq) void'(mq.pop_front());
      if (e_icr || e_dcr) mq.push_back(acc_ent);
    end
    if (e_icr) pref_dc = 1'b1;
    else if (e_dcr) pref_dc = 1'b0;
  endtask

  task automatic drain();
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    l2_req_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH && mq.size() > 0; i++) begin
      @(negedge clk); #1; predict(); commit();
    end
    @(negedge clk); #1;
    n_cmp++;
    if (fifo_count !== '0 || mq.size() != 0) begin
      n_bad++; $display("FAIL drain: fifo_count got %0d want 0 (model %0d)", fifo_count, mq.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; ic_req_valid = 1'b1; dc_req_valid = 1'b1; l2_req_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({req_valid, ic_req_ready, dc_req_ready, fifo_count} !== '0) begin
      n_bad++; $display("FAIL reset_outs: got vld=%b icr=%b dcr=%b cnt=%0d want all 0",
                        req_valid, ic_req_ready, dc_req_ready, fifo_count);
    end
    @(posedge clk);
    mq.delete(); pref_dc = 1'b0;
    @(negedge clk);
    rst = 1'b0; ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    #1;
    n_cmp++;
    if (req_valid !== 1'b0 || fifo_count !== '0) begin
      n_bad++; $display("FAIL post_reset: got vld=%b cnt=%0d want 0 0", req_valid, fifo_count);
    end
  endtask

  task automatic test_single_write();
    ent_t want;
    want = {1'b1, 30'h0000_0100, 1'b1, 4'b0011, 32'hDEAD_BEEF};
    @(negedge clk);
    dc_req_valid = 1'b1; dc_req_addr = 30'h0000_0100; dc_req_wen = 1'b1;
    dc_req_wmask = 4'b0011; dc_req_wdata = 32'hDEAD_BEEF; l2_req_ready = 1'b1;
    #1; predict();
    n_cmp++;
    if (dc_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL single_ready: got %b want 1", dc_req_ready);
    end
`ifdef L2REQFIFO_BYPASS_EN
    n_cmp++;
    if (req_valid !== 1'b1 || act_head !== want) begin
      n_bad++; $display("FAIL single_bypass: got vld=%b %h want 1 %h", req_valid, act_head, want);
    end
`endif
    commit();
    @(negedge clk);
    dc_req_valid = 1'b0;
    #1; predict();
`ifndef L2REQFIFO_BYPASS_EN
    n_cmp++;
    if (req_valid !== 1'b1 || act_head !== want || fifo_count !== CW'(1)) begin
      n_bad++; $display("FAIL single_out: got vld=%b %h cnt=%0d want 1 %h 1",
                        req_valid, act_head, fifo_count, want);
    end
`else
    n_cmp++;
    if (req_valid !== 1'b0 || fifo_count !== '0) begin
      n_bad++; $display("FAIL single_bypass_cnt: got vld=%b cnt=%0d want 0 0", req_valid, fifo_count);
    end
`endif
    commit();
    @(negedge clk); #1;
    n_cmp++;
    if (fifo_count !== '0) begin
      n_bad++; $display("FAIL single_cnt: got %0d want 0", fifo_count);
    end
  endtask

  task automatic test_round_robin();
    bit srcs[$];
    logic [1:0] want;
    l2_req_ready = 1'b1;
    ic_req_addr = 30'h10; dc_req_addr = 30'h20; dc_req_wen = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      ic_req_valid = (c < 4); dc_req_valid = (c < 4);
      #1; predict();
      if (c < 4) begin
        want = (c % 2 == 0) ? 2'b10 : 2'b01;
        n_cmp++;
        if ({ic_req_ready, dc_req_ready} !== want) begin
          n_bad++; $display("FAIL rr_grant%0d: got %b want %b", c, {ic_req_ready, dc_req_ready}, want);
        end
      end
      if (req_valid === 1'b1 && l2_req_ready) srcs.push_back(req_src);
      commit();
      @(posedge clk); #1;
      if (e_icr) ic_req_addr = ic_req_addr + 30'd1;
      if (e_dcr) dc_req_addr = dc_req_addr + 30'd1;
    end
    n_cmp++;
    if (srcs.size() != 4 || srcs[0] != 0 || srcs[1] != 1 || srcs[2] != 0 || srcs[3] != 1) begin
      n_bad++; $display("FAIL rr_src_seq: got %0d items %p want 0,1,0,1", srcs.size(), srcs);
    end
  endtask

  task automatic test_full();
    int a, next_exp;
    a = 1;
    l2_req_ready = 1'b0; ic_req_valid = 1'b0; dc_req_wen = 1'b1;
    for (int c = 0; c < 12 && a <= 8; c++) begin
      @(negedge clk);
      dc_req_valid = 1'b1; dc_req_addr = 30'(a); dc_req_wdata = 32'(a);
      #1; predict();
      n_cmp++;
      if (dc_req_ready !== 1'b1) begin
        n_bad++; $display("FAIL full_fill%0d: ready got %b want 1", a, dc_req_ready);
      end
      commit();
      if (e_dcr) a++;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      dc_req_addr = 30'd9; dc_req_wdata = 32'd9;
      #1; predict();
      n_cmp++;
      if (dc_req_ready !== 1'b0 || fifo_count !== CW'(DEPTH)) begin
        n_bad++; $display("FAIL full_hold: got rdy=%b cnt=%0d want 0 %0d", dc_req_ready, fifo_count, DEPTH);
      end
      commit();
    end
    next_exp = 1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      l2_req_ready = 1'b1;
      #1; predict();
      if (c < 2) begin
        n_cmp++;
        if (dc_req_ready !== 1'(c)) begin
          n_bad++; $display("FAIL full_9th_c%0d: ready got %b want %0d", c, dc_req_ready, c);
        end
      end
      if (req_valid === 1'b1) begin
        n_cmp++;
        if (req_addr !== 30'(next_exp)) begin
          n_bad++; $display("FAIL full_order: addr got %0d want %0d", req_addr, next_exp);
        end
        next_exp++;
      end
      commit();
      @(posedge clk); #1;
      if (e_dcr) dc_req_valid = 1'b0;
    end
    n_cmp++;
    if (next_exp != 10) begin
      n_bad++; $display("FAIL full_total: dequeued got %0d want 9", next_exp - 1);
    end
  endtask

  task automatic test_simultaneous();
    int a, next_exp;
    a = 100;
    l2_req_ready = 1'b0; ic_req_valid = 1'b0; dc_req_wen = 1'b0;
    for (int c = 0; c < 6 && a < 103; c++) begin
      @(negedge clk);
      dc_req_valid = 1'b1; dc_req_addr = 30'(a);
      #1; predict(); commit();
      if (e_dcr) a++;
    end
    next_exp = 100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      l2_req_ready = 1'b1; dc_req_valid = 1'b1; dc_req_addr = 30'(a);
      #1; predict();
      n_cmp++;
      if (dc_req_ready !== 1'b1 || fifo_count !== CW'(3) || req_addr !== 30'(next_exp)) begin
        n_bad++; $display("FAIL simul%0d: got rdy=%b cnt=%0d addr=%0d want 1 3 %0d",
                          c, dc_req_ready, fifo_count, req_addr, next_exp);
      end
      commit();
      next_exp++;
      if (e_dcr) a++;
    end
    drain();
  endtask

  task automatic test_mid_reset();
    int a;
    bit seen;
    a = 50;
    l2_req_ready = 1'b0; ic_req_valid = 1'b0;
    for (int c = 0; c < 10 && a < 55; c++) begin
      @(negedge clk);
      dc_req_valid = 1'b1; dc_req_addr = 30'(a);
      #1; predict(); commit();
      if (e_dcr) a++;
    end
    @(negedge clk);
    dc_req_valid = 1'b0;
    #1;
    n_cmp++;
    if (fifo_count !== CW'(5)) begin
      n_bad++; $display("FAIL mrst_fill: cnt got %0d want 5", fifo_count);
    end
    @(negedge clk);
    rst = 1'b1; dc_req_valid = 1'b1; dc_req_addr = 30'd77; l2_req_ready = 1'b1;
    #1;
    n_cmp++;
    if ({req_valid, ic_req_ready, dc_req_ready, fifo_count} !== '0) begin
      n_bad++; $display("FAIL mrst_cycle: got vld=%b dcr=%b cnt=%0d want 0 0 0",
                        req_valid, dc_req_ready, fifo_count);
    end
    @(posedge clk);
    mq.delete(); pref_dc = 1'b0;
    @(negedge clk);
    rst = 1'b0; dc_req_valid = 1'b0; l2_req_ready = 1'b0;
    #1;
    n_cmp++;
    if (req_valid !== 1'b0 || fifo_count !== '0) begin
      n_bad++; $display("FAIL mrst_after: got vld=%b cnt=%0d want 0 0", req_valid, fifo_count);
    end
    predict(); commit();
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      l2_req_ready = 1'b1; ic_req_valid = (c == 0); ic_req_addr = 30'h2AA;
      #1; predict();
      if (req_valid === 1'b1) begin
        seen = 1'b1;
        n_cmp++;
        if (req_addr !== 30'h2AA || req_src !== 1'b0) begin
          n_bad++; $display("FAIL mrst_first: got addr=%h src=%b want 2aa 0", req_addr, req_src);
        end
      end
      commit();
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL mrst_seen: got no request want one");
    end
    drain();
  endtask

  task automatic test_ic_max();
    ent_t want;
    bit seen;
    want = {1'b0, 30'h3FFF_FFFF, 1'b0, 4'h0, 32'h0};
    seen = 1'b0;
    dc_req_wen = 1'b1; dc_req_wmask = 4'hF; dc_req_wdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      l2_req_ready = 1'b1; dc_req_valid = 1'b0;
      ic_req_valid = (c == 0); ic_req_addr = 30'h3FFF_FFFF;
      #1; predict();
      if (req_valid === 1'b1) begin
        seen = 1'b1;
        n_cmp++;
        if (act_head !== want) begin
          n_bad++; $display("FAIL ic_max: got %h want %h", act_head, want);
        end
      end
      commit();
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL ic_max_seen: got no request want one");
    end
    drain();
  endtask

  task automatic test_random();
    bit ic_done, dc_done;
    ic_done = 1'b1; dc_done = 1'b1;
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (ic_done) begin
        ic_req_valid = 1'($urandom_range(0, 1));
        ic_req_addr = 30'($urandom);
      end
      if (dc_done) begin
        dc_req_valid = 1'($urandom_range(0, 1));
        dc_req_addr = 30'($urandom);
        dc_req_wen = 1'($urandom);
        dc_req_wmask = 4'($urandom);
        dc_req_wdata = $urandom;
      end
      l2_req_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      #1; predict();
      n_cmp++;
      if ({ic_req_ready, dc_req_ready, req_valid, fifo_count} !== {e_icr, e_dcr, e_vld, e_cnt}) begin
        n_bad++; $display("FAIL rand_ctl%0d: got icr=%b dcr=%b vld=%b cnt=%0d want %b %b %b %0d",
                          c, ic_req_ready, dc_req_ready, req_valid, fifo_count,
                          e_icr, e_dcr, e_vld, e_cnt);
      end
      if (e_vld) begin
        n_cmp++;
        if (act_head !== e_head) begin
          n_bad++; $display("FAIL rand_head%0d: got %h want %h", c, act_head, e_head);
        end
      end
      commit();
      ic_done = !ic_req_valid || e_icr;
      dc_done = !dc_req_valid || e_dcr;
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; ic_req_valid = 1'b0; dc_req_valid = 1'b0; l2_req_ready = 1'b0;
    ic_req_addr = '0; dc_req_addr = '0; dc_req_wen = 1'b0; dc_req_wmask = '0; dc_req_wdata = '0;
    pref_dc = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_full();
    test_simultaneous();
    test_mid_reset();
    test_ic_max();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
